mem_port_arbiter: RTL and testbench

Arbiter and sequencer that shares a single-ported instruction/data memory between the fetch stage and the memory stage of the pipelined RV32I core. It accepts word fetches and LBU/SB data accesses, issues them to the memory one at a time, and tracks the fixed read latency with a counter. It returns acknowledges and stall signals to the hazard logic, and discards fetches squashed by a taken branch or jump.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported instruction/data memory between the fetch stage and
// the memory stage of the RV32I pipeline. Data accesses always win over
// fetches. Only one access is outstanding at a time. A small down-counter
// tracks the fixed memory read latency. A fetch squashed by a branch or jump
// is allowed to finish in the memory but produces no acknowledge.
//
// Parameters:
//   MEM_LATENCY  cycles from issue to valid mem_rdata (1..4)
//   ADDR_WIDTH   byte address width
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr/if_cancel      fetch request, address, squash
//   if_rdata/if_ack/if_stall      fetch data, completion pulse, stall
//   dm_req/dm_we/dm_byte          data request, store select, byte access
//   dm_addr/dm_wdata              data address, store data
//   dm_rdata/dm_ack/dm_stall      load data, completion pulse, stall
//   mem_en/mem_we/mem_byte        memory issue strobe and access type
//   mem_addr/mem_wdata/mem_rdata  memory address, write data, read data
//   perf_if_wait/perf_dm_wait     stall-cycle counters
//
// Optional feature: define ARB_STATS_EN to build the two stall-cycle
// counters. When it is undefined, both perf outputs are constant 0.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_cancel,
    output logic [31:0]           if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic                  dm_byte,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [31:0]           dm_wdata,
    output logic [31:0]           dm_rdata,
    output logic                  dm_ack,
    output logic                  dm_stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_byte,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           perf_if_wait,
    output logic [31:0]           perf_dm_wait
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_IF_DROP,
        BUSY_DM,
        BUSY_DM_WR
    } state_t;

    // Counter start value; the last BUSY cycle is the one where it reads 0.
    localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       last_q;

    assign last_q = (cnt_q == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_byte  = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        if_ack    = 1'b0;
        if_rdata  = 32'd0;
        dm_ack    = 1'b0;
        dm_rdata  = 32'd0;

        case (state_q)
            IDLE: begin
                // Issue is suppressed while reset is held so that every
                // output reads 0 during reset.
                if (!rst) begin
                    if (dm_req) begin
                        mem_en    = 1'b1;
                        mem_we    = dm_we;
                        mem_byte  = dm_byte;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        cnt_d     = LAT_M1;
                        state_d   = dm_we ? BUSY_DM_WR : BUSY_DM;
                    end else if (if_req && !if_cancel) begin
                        mem_en   = 1'b1;
                        mem_addr = if_addr;
                        cnt_d    = LAT_M1;
                        state_d  = BUSY_IF;
                    end
                end
            end

            BUSY_IF: begin
                if (last_q) begin
                    // A squash arriving in the data cycle still kills the ack.
                    if (!if_cancel && !rst) begin
                        if_ack   = 1'b1;
                        if_rdata = mem_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                    if (if_cancel) begin
                        state_d = BUSY_IF_DROP;
                    end
                end
            end

            BUSY_IF_DROP: begin
                // Let the squashed read drain so the memory is free again.
                if (last_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            BUSY_DM: begin
                if (last_q) begin
                    if (!rst) begin
                        dm_ack   = 1'b1;
                        dm_rdata = mem_rdata;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            BUSY_DM_WR: begin
                // Stores complete one cycle after issue regardless of latency.
                dm_ack  = !rst;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack;

`ifdef ARB_STATS_EN
    logic [31:0] perf_if_q, perf_dm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_if_q <= 32'd0;
            perf_dm_q <= 32'd0;
        end else begin
            if (if_stall) perf_if_q <= perf_if_q + 32'd1;
            if (dm_stall) perf_dm_q <= perf_dm_q + 32'd1;
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_dm_wait = perf_dm_q;
`else
    assign perf_if_wait = 32'd0;
    assign perf_dm_wait = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_port_arbiter. Four instances (MEM_LATENCY 1..4) share the
// same stimulus; each scenario observes the instance with its latency.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
// Cycle 0 of a scenario is the first falling edge after reset is released.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_cancel, dm_req, dm_we, dm_byte;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;

    logic [31:0] if_rdata_w  [1:4];
    logic        if_ack_w    [1:4];
    logic        if_stall_w  [1:4];
    logic [31:0] dm_rdata_w  [1:4];
    logic        dm_ack_w    [1:4];
    logic        dm_stall_w  [1:4];
    logic        mem_en_w    [1:4];
    logic        mem_we_w    [1:4];
    logic        mem_byte_w  [1:4];
    logic [31:0] mem_addr_w  [1:4];
    logic [31:0] mem_wdata_w [1:4];
    logic [31:0] perf_if_w   [1:4];
    logic [31:0] perf_dm_w   [1:4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 1; gi <= 4; gi++) begin : g_dut
            mem_port_arbiter #(.MEM_LATENCY(gi), .ADDR_WIDTH(32)) u_dut (
                .clk          (clk),
                .rst          (rst),
                .if_req       (if_req),
                .if_addr      (if_addr),
                .if_cancel    (if_cancel),
                .if_rdata     (if_rdata_w[gi]),
                .if_ack       (if_ack_w[gi]),
                .if_stall     (if_stall_w[gi]),
                .dm_req       (dm_req),
                .dm_we        (dm_we),
                .dm_byte      (dm_byte),
                .dm_addr      (dm_addr),
                .dm_wdata     (dm_wdata),
                .dm_rdata     (dm_rdata_w[gi]),
                .dm_ack       (dm_ack_w[gi]),
                .dm_stall     (dm_stall_w[gi]),
                .mem_en       (mem_en_w[gi]),
                .mem_we       (mem_we_w[gi]),
                .mem_byte     (mem_byte_w[gi]),
                .mem_addr     (mem_addr_w[gi]),
                .mem_wdata    (mem_wdata_w[gi]),
                .mem_rdata    (mem_rdata),
                .perf_if_wait (perf_if_w[gi]),
                .perf_dm_wait (perf_dm_w[gi])
            );
        end
    endgenerate

    task automatic clear_inputs();
        if_req = 0; if_cancel = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_byte = 0; dm_addr = 0; dm_wdata = 0;
        mem_rdata = 0;
    endtask

    // Two cycles of reset with requests low; returns on the falling edge
    // where rst is released.
    task automatic do_reset();
        @(negedge clk); rst = 1; clear_inputs();
        @(negedge clk);
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1; clear_inputs();
        @(negedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({mem_en_w[i], mem_we_w[i], mem_byte_w[i], if_ack_w[i], dm_ack_w[i],
                 if_stall_w[i], dm_stall_w[i]} !== 7'b0) begin
                errors++;
                $display("FAIL reset_flags L=%0d: got %b want 0", i,
                         {mem_en_w[i], mem_we_w[i], mem_byte_w[i], if_ack_w[i], dm_ack_w[i],
                          if_stall_w[i], dm_stall_w[i]});
            end
            checks++;
            if ((mem_addr_w[i] | mem_wdata_w[i] | if_rdata_w[i] | dm_rdata_w[i] |
                 perf_if_w[i] | perf_dm_w[i]) !== 32'd0) begin
                errors++;
                $display("FAIL reset_data L=%0d: got nonzero bus, want 0", i);
            end
        end
        // A request held during reset must not be issued.
        dm_req = 1; dm_addr = 32'h100;
        #1;
        checks++;
        if (mem_en_w[1] !== 1'b0) begin
            errors++; $display("FAIL reset_no_issue: mem_en=%b want 0", mem_en_w[1]);
        end
        $display("test_reset: done");
        @(negedge clk); rst = 0; clear_inputs();
    endtask

    // MEM_LATENCY=1 fetch, then a fetch squashed in its data cycle.
    task automatic test_fetch();
        do_reset();
        @(negedge clk); if_req = 1; if_addr = 32'h4; mem_rdata = 32'h0050_0093;
        #1;
        checks++;
        if ({mem_en_w[1], if_stall_w[1], if_ack_w[1]} !== 3'b110 || mem_addr_w[1] !== 32'h4) begin
            errors++;
            $display("FAIL fetch_c0: en/stall/ack=%b addr=%h want 110 00000004",
                     {mem_en_w[1], if_stall_w[1], if_ack_w[1]}, mem_addr_w[1]);
        end
        @(negedge clk); #1;
        checks++;
        if ({mem_en_w[1], if_stall_w[1], if_ack_w[1]} !== 3'b001 || if_rdata_w[1] !== 32'h0050_0093) begin
            errors++;
            $display("FAIL fetch_c1: en/stall/ack=%b rdata=%h want 001 00500093",
                     {mem_en_w[1], if_stall_w[1], if_ack_w[1]}, if_rdata_w[1]);
        end
        $display("test_fetch: L=1 fetch 0x4 -> %h", if_rdata_w[1]);
        // Next fetch issued in cycle 2, cancelled in its final cycle 3.
        @(negedge clk); if_addr = 32'h8; #1;
        checks++;
        if (mem_en_w[1] !== 1'b1) begin
            errors++; $display("FAIL fetch2_issue: mem_en=%b want 1", mem_en_w[1]);
        end
        @(negedge clk); if_cancel = 1; if_req = 0; #1;
        checks++;
        if (if_ack_w[1] !== 1'b0 || if_rdata_w[1] !== 32'd0) begin
            errors++;
            $display("FAIL fetch_cancel_last: ack=%b rdata=%h want 0 0", if_ack_w[1], if_rdata_w[1]);
        end
        $display("test_fetch: late-cancel ack=%b", if_ack_w[1]);
        @(negedge clk); clear_inputs();
    endtask

    // MEM_LATENCY=2, load and fetch raised together; data wins.
    task automatic test_priority();
        logic [6:0] en_exp    = 7'b0001001;
        logic [6:0] dack_exp  = 7'b0000100;
        logic [6:0] iack_exp  = 7'b0100000;
        logic [6:0] stall_exp = 7'b0011111;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                if_req = 1; if_addr = 32'h8;
                dm_req = 1; dm_we = 0; dm_byte = 1; dm_addr = 32'h0001_0000;
                mem_rdata = 32'h0000_00C5;
            end
            if (c == 3) begin dm_req = 0; mem_rdata = 32'h0000_0013; end
            if (c == 6) if_req = 0;
            #1;
            checks++;
            if ({mem_en_w[2], dm_ack_w[2], if_ack_w[2], if_stall_w[2]} !==
                {en_exp[c], dack_exp[c], iack_exp[c], stall_exp[c]}) begin
                errors++;
                $display("FAIL prio_c%0d: en/dack/iack/istall=%b want %b", c,
                         {mem_en_w[2], dm_ack_w[2], if_ack_w[2], if_stall_w[2]},
                         {en_exp[c], dack_exp[c], iack_exp[c], stall_exp[c]});
            end
            if (c == 0) begin
                checks++;
                if (mem_addr_w[2] !== 32'h0001_0000 || mem_byte_w[2] !== 1'b1 || mem_we_w[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL prio_dm_issue: addr=%h byte=%b we=%b want 00010000 1 0",
                             mem_addr_w[2], mem_byte_w[2], mem_we_w[2]);
                end
            end
            if (c == 2) begin
                checks++;
                if (dm_rdata_w[2] !== 32'h0000_00C5) begin
                    errors++; $display("FAIL prio_dm_rdata: got %h want 000000c5", dm_rdata_w[2]);
                end
            end
            if (c == 3) begin
                checks++;
                if (mem_addr_w[2] !== 32'h8 || mem_byte_w[2] !== 1'b0) begin
                    errors++;
                    $display("FAIL prio_if_issue: addr=%h byte=%b want 00000008 0",
                             mem_addr_w[2], mem_byte_w[2]);
                end
            end
            if (c == 5) begin
                checks++;
                if (if_rdata_w[2] !== 32'h0000_0013) begin
                    errors++; $display("FAIL prio_if_rdata: got %h want 00000013", if_rdata_w[2]);
                end
            end
            if (c == 6) begin
`ifdef ARB_STATS_EN
                checks++;
                if (perf_if_w[2] !== 32'd5 || perf_dm_w[2] !== 32'd2) begin
                    errors++;
                    $display("FAIL perf_counts: if=%0d dm=%0d want 5 2", perf_if_w[2], perf_dm_w[2]);
                end
`else
                checks++;
                if (perf_if_w[2] !== 32'd0 || perf_dm_w[2] !== 32'd0) begin
                    errors++;
                    $display("FAIL perf_counts: if=%0d dm=%0d want 0 0", perf_if_w[2], perf_dm_w[2]);
                end
`endif
            end
            $display("test_priority: cycle %0d en=%b dack=%b iack=%b perf_if=%0d",
                     c, mem_en_w[2], dm_ack_w[2], if_ack_w[2], perf_if_w[2]);
        end
        clear_inputs();
    endtask

    // MEM_LATENCY=3 byte store completes in one cycle.
    task automatic test_store();
        do_reset();
        @(negedge clk);
        dm_req = 1; dm_we = 1; dm_byte = 1; dm_addr = 32'h0001_0003; dm_wdata = 32'hAB;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({mem_en_w[3], mem_we_w[3], mem_byte_w[3]} !== 3'b111 ||
            mem_wdata_w[3] !== 32'h0000_00AB || mem_addr_w[3] !== 32'h0001_0003) begin
            errors++;
            $display("FAIL store_issue: en/we/byte=%b wdata=%h addr=%h want 111 000000ab 00010003",
                     {mem_en_w[3], mem_we_w[3], mem_byte_w[3]}, mem_wdata_w[3], mem_addr_w[3]);
        end
        @(negedge clk); #1;
        checks++;
        if (dm_ack_w[3] !== 1'b1 || dm_rdata_w[3] !== 32'd0 || dm_stall_w[3] !== 1'b0) begin
            errors++;
            $display("FAIL store_ack: ack=%b rdata=%h stall=%b want 1 00000000 0",
                     dm_ack_w[3], dm_rdata_w[3], dm_stall_w[3]);
        end
        $display("test_store: SB 0x10003 ack=%b", dm_ack_w[3]);
        @(negedge clk); dm_req = 0; #1;
        checks++;
        if (mem_en_w[3] !== 1'b0 || dm_ack_w[3] !== 1'b0) begin
            errors++;
            $display("FAIL store_after: en=%b ack=%b want 0 0", mem_en_w[3], dm_ack_w[3]);
        end
        clear_inputs();
    endtask

    // MEM_LATENCY=3 fetch squashed in cycle 1; pending load issued in cycle 4.
    task automatic test_cancel();
        do_reset();
        @(negedge clk); if_req = 1; if_addr = 32'h20; mem_rdata = 32'h1111_2222; #1;
        checks++;
        if (mem_en_w[3] !== 1'b1) begin
            errors++; $display("FAIL cancel_issue: mem_en=%b want 1", mem_en_w[3]);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if_cancel = 1; if_req = 0;
                dm_req = 1; dm_we = 0; dm_byte = 1; dm_addr = 32'h30;
            end
            if (c == 2) if_cancel = 0;
            #1;
            checks++;
            if (if_ack_w[3] !== 1'b0 || mem_en_w[3] !== (c == 4) || dm_stall_w[3] !== 1'b1) begin
                errors++;
                $display("FAIL cancel_c%0d: iack=%b en=%b dstall=%b want 0 %b 1",
                         c, if_ack_w[3], mem_en_w[3], dm_stall_w[3], (c == 4));
            end
            $display("test_cancel: cycle %0d iack=%b en=%b", c, if_ack_w[3], mem_en_w[3]);
        end
        checks++;
        if (mem_addr_w[3] !== 32'h30 || mem_we_w[3] !== 1'b0) begin
            errors++;
            $display("FAIL cancel_dm_issue: addr=%h we=%b want 00000030 0", mem_addr_w[3], mem_we_w[3]);
        end
        clear_inputs();
    endtask

    // MEM_LATENCY=4 load abandoned by reset in cycle 1.
    task automatic test_reset_mid();
        do_reset();
        @(negedge clk); dm_req = 1; dm_we = 0; dm_addr = 32'h0001_0000; mem_rdata = 32'h55; #1;
        checks++;
        if (mem_en_w[4] !== 1'b1) begin
            errors++; $display("FAIL rmid_issue: mem_en=%b want 1", mem_en_w[4]);
        end
        @(negedge clk); rst = 1; #1;
        checks++;
        if (dm_ack_w[4] !== 1'b0 || mem_en_w[4] !== 1'b0) begin
            errors++; $display("FAIL rmid_c1: ack=%b en=%b want 0 0", dm_ack_w[4], mem_en_w[4]);
        end
        @(negedge clk); dm_req = 0; #1;
        checks++;
        if ({mem_en_w[4], dm_ack_w[4], dm_stall_w[4], if_ack_w[4]} !== 4'b0 ||
            (mem_addr_w[4] | dm_rdata_w[4] | perf_dm_w[4]) !== 32'd0) begin
            errors++;
            $display("FAIL rmid_c2: en/dack/dstall/iack=%b bus=%h want 0",
                     {mem_en_w[4], dm_ack_w[4], dm_stall_w[4], if_ack_w[4]},
                     mem_addr_w[4] | dm_rdata_w[4] | perf_dm_w[4]);
        end
        @(negedge clk); rst = 0; if_req = 1; if_addr = 32'h40; mem_rdata = 32'h0000_0073; #1;
        checks++;
        if (mem_en_w[4] !== 1'b1 || mem_addr_w[4] !== 32'h40) begin
            errors++;
            $display("FAIL rmid_fetch: en=%b addr=%h want 1 00000040", mem_en_w[4], mem_addr_w[4]);
        end
        for (int c = 4; c <= 7; c++) begin
            @(negedge clk); #1;
            checks++;
            if (dm_ack_w[4] !== 1'b0 || if_ack_w[4] !== (c == 7)) begin
                errors++;
                $display("FAIL rmid_c%0d: dack=%b iack=%b want 0 %b", c, dm_ack_w[4], if_ack_w[4], (c == 7));
            end
            $display("test_reset_mid: cycle %0d dack=%b iack=%b", c, dm_ack_w[4], if_ack_w[4]);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_cancel();
        test_reset_mid();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
